// File: rtl/por_sequencer.sv
// Power-up sequencer for two POR-monitored supply domains: enables domain 1, waits for
// its debounced POR-good, settles, enables domain 2, then watches both for brownout.
module por_sequencer #(
    parameter int DEBOUNCE_CYCLES = 16,
    parameter int TIMEOUT_CYCLES  = 4096,
    parameter int SETTLE_CYCLES   = 8
) (
    input  logic       clock,
    input  logic       resetb,
    input  logic       start,
    input  logic       clear,
    input  logic [1:0] por_in,
    output logic [1:0] en_out,
    output logic [1:0] status,
    output logic [3:0] checkbits,
    output logic       fault,
    output logic       done
);

    localparam int DW = $clog2(DEBOUNCE_CYCLES + 1);
    localparam int TW = $clog2(TIMEOUT_CYCLES + 1);
    localparam int SW = $clog2(SETTLE_CYCLES + 1);

    typedef enum logic [2:0] {
        ST_IDLE   = 3'd0,
        ST_WAIT1  = 3'd1,
        ST_SETTLE = 3'd2,
        ST_WAIT2  = 3'd3,
        ST_READY  = 3'd4,
        ST_FAULT  = 3'd5
    } state_t;

    state_t          r_state;
    state_t          w_next_state;
    logic [1:0]      r_sync1;
    logic [1:0]      r_por_s;
    logic [DW-1:0]   r_deb0;
    logic [DW-1:0]   r_deb1;
    logic [TW-1:0]   r_to;
    logic [SW-1:0]   r_set;
    logic            r_fcode;
    logic            w_fcode;
    logic            w_watch0;
    logic            w_lvl0;
    logic            w_watch1;
    logic            w_lvl1;
    logic            w_match0;
    logic            w_match1;
    logic            w_deb0_done;
    logic            w_deb1_done;
    logic            w_to_done;
    logic            w_set_done;
    logic            w_in_wait;
    logic            w_state_chg;
    logic [1:0]      w_en;
    logic [1:0]      w_status;
    logic [3:0]      w_check;
    logic            w_fault;
    logic            w_done;

    // Per-state choice of which domains are watched and at which awaited POR level.
    always_comb begin
        w_watch0 = 1'b0;
        w_lvl0   = 1'b0;
        w_watch1 = 1'b0;
        w_lvl1   = 1'b0;
        case (r_state)
            ST_WAIT1: begin
                w_watch0 = 1'b1;
                w_lvl0   = 1'b1;
            end
            ST_SETTLE: begin
                w_watch0 = 1'b1;
            end
            ST_WAIT2: begin
                w_watch0 = 1'b1;
                w_watch1 = 1'b1;
                w_lvl1   = 1'b1;
            end
            ST_READY: begin
                w_watch0 = 1'b1;
                w_watch1 = 1'b1;
            end
            default: begin
                w_watch0 = 1'b0;
            end
        endcase
    end

    assign w_match0    = w_watch0 && (r_por_s[0] == w_lvl0);
    assign w_match1    = w_watch1 && (r_por_s[1] == w_lvl1);
    // The current sample is the last of the required run when the counter already holds N-1.
    assign w_deb0_done = w_match0 && (r_deb0 == DW'(DEBOUNCE_CYCLES - 1));
    assign w_deb1_done = w_match1 && (r_deb1 == DW'(DEBOUNCE_CYCLES - 1));
    assign w_in_wait   = (r_state == ST_WAIT1) || (r_state == ST_WAIT2);
    assign w_to_done   = w_in_wait && (r_to == TW'(TIMEOUT_CYCLES - 1));
    assign w_set_done  = (r_state == ST_SETTLE) && (r_set == SW'(SETTLE_CYCLES - 1));
    assign w_state_chg = (w_next_state != r_state);

    // Next-state selection; timeout beats debounce, domain 0 beats domain 1.
    always_comb begin
        w_next_state = r_state;
        w_fcode      = r_fcode;
        case (r_state)
            ST_IDLE: begin
                if (start) w_next_state = ST_WAIT1;
                else       w_next_state = ST_IDLE;
            end
            ST_WAIT1: begin
                if (w_to_done) begin
                    w_next_state = ST_FAULT;
                    w_fcode      = 1'b0;
                end else if (w_deb0_done) begin
                    w_next_state = ST_SETTLE;
                end else begin
                    w_next_state = ST_WAIT1;
                end
            end
            ST_SETTLE: begin
                if (w_deb0_done) begin
                    w_next_state = ST_FAULT;
                    w_fcode      = 1'b0;
                end else if (w_set_done) begin
                    w_next_state = ST_WAIT2;
                end else begin
                    w_next_state = ST_SETTLE;
                end
            end
            ST_WAIT2: begin
                if (w_to_done) begin
                    w_next_state = ST_FAULT;
                    w_fcode      = 1'b1;
                end else if (w_deb0_done) begin
                    w_next_state = ST_FAULT;
                    w_fcode      = 1'b0;
                end else if (w_deb1_done) begin
                    w_next_state = ST_READY;
                end else begin
                    w_next_state = ST_WAIT2;
                end
            end
            ST_READY: begin
                if (w_deb0_done) begin
                    w_next_state = ST_FAULT;
                    w_fcode      = 1'b0;
                end else if (w_deb1_done) begin
                    w_next_state = ST_FAULT;
                    w_fcode      = 1'b1;
                end else begin
                    w_next_state = ST_READY;
                end
            end
            ST_FAULT: begin
                if (clear) w_next_state = ST_IDLE;
                else       w_next_state = ST_FAULT;
            end
            default: begin
                w_next_state = ST_IDLE;
            end
        endcase
    end

    // Output decode from the next state so registered outputs change on the entry edge.
    always_comb begin
        w_en     = 2'b00;
        w_status = 2'b00;
        w_check  = 4'h0;
        w_fault  = 1'b0;
        w_done   = 1'b0;
        case (w_next_state)
            ST_WAIT1: begin
                w_en = 2'b01;
            end
            ST_SETTLE: begin
                w_en     = 2'b01;
                w_status = 2'b01;
                w_check  = 4'h9;
            end
            ST_WAIT2: begin
                w_en     = 2'b11;
                w_status = 2'b01;
                w_check  = 4'h9;
            end
            ST_READY: begin
                w_en     = 2'b11;
                w_status = 2'b11;
                w_check  = 4'h5;
                w_done   = 1'b1;
            end
            ST_FAULT: begin
                w_status = 2'b10;
                w_check  = {3'b110, w_fcode};
                w_fault  = 1'b1;
            end
            default: begin
                w_en = 2'b00;
            end
        endcase
    end

    // State, synchronizer, saturating counters and registered outputs.
    always_ff @(posedge clock) begin
        if (!resetb) begin
            r_state   <= ST_IDLE;
            r_sync1   <= 2'b00;
            r_por_s   <= 2'b00;
            r_deb0    <= '0;
            r_deb1    <= '0;
            r_to      <= '0;
            r_set     <= '0;
            r_fcode   <= 1'b0;
            en_out    <= 2'b00;
            status    <= 2'b00;
            checkbits <= 4'h0;
            fault     <= 1'b0;
            done      <= 1'b0;
        end else begin
            r_state   <= w_next_state;
            r_sync1   <= por_in;
            r_por_s   <= r_sync1;
            r_fcode   <= w_fcode;
            en_out    <= w_en;
            status    <= w_status;
            checkbits <= w_check;
            fault     <= w_fault;
            done      <= w_done;

            if (w_state_chg || !w_match0)
                r_deb0 <= '0;
            else if (r_deb0 != DW'(DEBOUNCE_CYCLES))
                r_deb0 <= r_deb0 + DW'(1);
            else
                r_deb0 <= r_deb0;

            if (w_state_chg || !w_match1)
                r_deb1 <= '0;
            else if (r_deb1 != DW'(DEBOUNCE_CYCLES))
                r_deb1 <= r_deb1 + DW'(1);
            else
                r_deb1 <= r_deb1;

            if (w_state_chg)
                r_to <= '0;
            else if (w_in_wait && (r_to != TW'(TIMEOUT_CYCLES)))
                r_to <= r_to + TW'(1);
            else
                r_to <= r_to;

            if (w_state_chg)
                r_set <= '0;
            else if ((r_state == ST_SETTLE) && (r_set != SW'(SETTLE_CYCLES)))
                r_set <= r_set + SW'(1);
            else
                r_set <= r_set;
        end
    end

endmodule

// File: tb/tb_por_sequencer.sv
// Scoreboard bench for por_sequencer: expected output vectors are queued with the edge
// number at which they must appear and compared on the following falling edge.
module tb_por_sequencer;

    logic       clock = 1'b0;
    logic       resetb;
    logic       start;
    logic       clear;
    logic [1:0] por_in;
    logic [1:0] en_out;
    logic [1:0] status;
    logic [3:0] checkbits;
    logic       fault;
    logic       done;

    por_sequencer dut (
        .clock     (clock),
        .resetb    (resetb),
        .start     (start),
        .clear     (clear),
        .por_in    (por_in),
        .en_out    (en_out),
        .status    (status),
        .checkbits (checkbits),
        .fault     (fault),
        .done      (done)
    );

    always #5 clock = ~clock;

    // {en_out, status, checkbits, fault, done}
    localparam logic [9:0] V_IDLE   = {2'b00, 2'b00, 4'h0, 1'b0, 1'b0};
    localparam logic [9:0] V_WAIT1  = {2'b01, 2'b00, 4'h0, 1'b0, 1'b0};
    localparam logic [9:0] V_SETTLE = {2'b01, 2'b01, 4'h9, 1'b0, 1'b0};
    localparam logic [9:0] V_WAIT2  = {2'b11, 2'b01, 4'h9, 1'b0, 1'b0};
    localparam logic [9:0] V_READY  = {2'b11, 2'b11, 4'h5, 1'b0, 1'b1};
    localparam logic [9:0] V_FAULT0 = {2'b00, 2'b10, 4'hC, 1'b1, 1'b0};
    localparam logic [9:0] V_FAULT1 = {2'b00, 2'b10, 4'hD, 1'b1, 1'b0};

    typedef struct {
        int          due;
        logic [9:0]  exp;
        logic [95:0] tag;
    } sb_t;

    sb_t sb_q[$];
    int  cyc     = 0;
    int  n_check = 0;
    int  n_pass  = 0;
    int  s;
    int  r;
    int  x;

    always @(posedge clock) cyc <= cyc + 1;

    task automatic check(input logic [95:0] tag, input logic [9:0] got, input logic [9:0] exp);
        n_check++;
        if (got === exp) n_pass++;
        else $display("FAIL %0s: got %b expected %b (edge %0d)", tag, got, exp, cyc);
    endtask

    task automatic expect_at(input int due, input logic [9:0] exp, input logic [95:0] tag);
        sb_t e;
        e.due = due;
        e.exp = exp;
        e.tag = tag;
        sb_q.push_back(e);
    endtask

    always @(negedge clock) begin
        while (sb_q.size() > 0 && sb_q[0].due <= cyc) begin
            sb_t e;
            e = sb_q.pop_front();
            check(e.tag, {en_out, status, checkbits, fault, done}, e.exp);
        end
    end

    task automatic wait_cycles(input int n);
        repeat (n) begin
            @(posedge clock);
            #1;
        end
    endtask

    task automatic wait_until(input int c);
        while (cyc < c) begin
            @(posedge clock);
            #1;
        end
    endtask

    task automatic do_reset(input int n);
        resetb = 1'b0;
        wait_cycles(n);
        resetb = 1'b1;
        expect_at(cyc, V_IDLE, "rst_idle");
    endtask

    task automatic pulse_start();
        start = 1'b1;
        wait_cycles(1);
        start = 1'b0;
    endtask

    task automatic pulse_clear();
        clear = 1'b1;
        wait_cycles(1);
        clear = 1'b0;
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation did not finish, edge %0d", cyc);
        $fatal(1, "watchdog expired");
    end

    initial begin
        resetb = 1'b0;
        start  = 1'b0;
        clear  = 1'b0;
        por_in = 2'b11;
        #1;

        // Nominal sequence with both supplies already good
        do_reset(4);
        wait_cycles(3);
        s = cyc;
        expect_at(s + 1,  V_WAIT1,  "t1_wait1");
        expect_at(s + 16, V_WAIT1,  "t1_wait1_end");
        expect_at(s + 17, V_SETTLE, "t1_settle");
        expect_at(s + 24, V_SETTLE, "t1_settle_end");
        expect_at(s + 25, V_WAIT2,  "t1_wait2");
        expect_at(s + 40, V_WAIT2,  "t1_wait2_end");
        expect_at(s + 41, V_READY,  "t1_ready");
        pulse_start();
        wait_until(s + 42);

        // start while READY has no effect
        s = cyc;
        expect_at(s + 1, V_READY, "t6_start_rdy");
        expect_at(s + 3, V_READY, "t6_start_rdy2");
        pulse_start();
        wait_until(s + 4);

        // 10-cycle glitch on domain 2 is rejected
        s = cyc;
        por_in = 2'b01;
        wait_cycles(10);
        por_in = 2'b11;
        expect_at(s + 15, V_READY, "t4_glitch");
        expect_at(s + 30, V_READY, "t4_glitch2");
        wait_until(s + 31);

        // sustained drop of domain 2 faults with code D
        s = cyc;
        por_in = 2'b01;
        expect_at(s + 17, V_READY,  "t4_pre_fault");
        expect_at(s + 18, V_FAULT1, "t4_fault_d");
        wait_until(s + 19);

        // start ignored in FAULT, clear returns to IDLE
        s = cyc;
        expect_at(s + 1, V_FAULT1, "fault_nostart");
        expect_at(s + 3, V_FAULT1, "fault_hold");
        pulse_start();
        wait_until(s + 4);
        por_in = 2'b11;
        s = cyc;
        expect_at(s + 1, V_IDLE, "t4_clear");
        pulse_clear();
        wait_until(s + 3);

        // both domains drop together: domain 0 reported
        s = cyc;
        expect_at(s + 41, V_READY, "t6_ready");
        pulse_start();
        wait_until(s + 42);
        s = cyc;
        por_in = 2'b00;
        expect_at(s + 18, V_FAULT0, "t6_both_drop");
        wait_until(s + 19);
        por_in = 2'b11;

        // start and clear together in FAULT: IDLE, no WAIT1
        s = cyc;
        expect_at(s + 1, V_IDLE, "t6_st_clr");
        expect_at(s + 2, V_IDLE, "t6_no_wait1");
        expect_at(s + 6, V_IDLE, "t6_no_wait1b");
        start = 1'b1;
        clear = 1'b1;
        wait_cycles(1);
        start = 1'b0;
        clear = 1'b0;
        wait_until(s + 7);

        // reset in WAIT2, then a full replay
        s = cyc;
        expect_at(s + 30, V_WAIT2, "t5_in_wait2");
        pulse_start();
        wait_until(s + 30);
        x = cyc;
        resetb = 1'b0;
        expect_at(x + 1, V_IDLE, "t5_reset");
        wait_cycles(1);
        resetb = 1'b1;
        wait_until(x + 3);
        s = cyc;
        expect_at(s + 1,  V_WAIT1,  "t5_wait1");
        expect_at(s + 17, V_SETTLE, "t5_settle");
        expect_at(s + 25, V_WAIT2,  "t5_wait2");
        expect_at(s + 41, V_READY,  "t5_ready");
        pulse_start();
        wait_until(s + 42);

        // late domain-2 supply
        por_in = 2'b01;
        do_reset(2);
        wait_cycles(3);
        s = cyc;
        expect_at(s + 25, V_WAIT2, "t2_wait2");
        pulse_start();
        wait_until(s + 525);
        r = cyc;
        por_in = 2'b11;
        expect_at(r + 17, V_WAIT2, "t2_pre_ready");
        expect_at(r + 18, V_READY, "t2_ready");
        expect_at(r + 30, V_READY, "t2_ready_hold");
        wait_until(r + 31);

        // domain 1 never comes up: timeout
        por_in = 2'b10;
        do_reset(2);
        wait_cycles(3);
        s = cyc;
        expect_at(s + 1,    V_WAIT1,  "t3_wait1");
        expect_at(s + 4096, V_WAIT1,  "t3_pre_to");
        expect_at(s + 4097, V_FAULT0, "t3_timeout");
        pulse_start();
        wait_until(s + 4098);
        s = cyc;
        expect_at(s + 1, V_IDLE, "t3_clear");
        pulse_clear();
        wait_until(s + 3);

        wait_cycles(2);
        n_check++;
        if (sb_q.size() == 0) n_pass++;
        else $display("FAIL sb_drain: %0d entries left, expected 0", sb_q.size());

        $display("%0d/%0d checks passed", n_pass, n_check);
        $finish;
    end

endmodule

// File: doc/por_sequencer.md
Name: por_sequencer

Overview:
Power-up sequencer for the two POR-monitored supply domains on the analog user project.
- Enables domain 1 and waits for its POR-good indication; after a settle interval, enables domain 2 and waits for its POR-good.
- Reports progress on a 2-bit status code and a 4-bit check code routed to GPIO pads for off-chip readback.
- Detects timeout and brownout and latches a fault until cleared.

Parameters:
DEBOUNCE_CYCLES, 16, consecutive synchronized samples required to accept a POR level change (>=2)
TIMEOUT_CYCLES, 4096, max cycles in a WAIT state before fault (> DEBOUNCE_CYCLES+2)
SETTLE_CYCLES, 8, cycles between domain-1 good and domain-2 enable (>=1)

Ports:
clock  input  1  system clock
resetb  input  1  synchronous active-low reset
start  input  1  one-cycle pulse; begins sequence (honoured only in IDLE)
clear  input  1  one-cycle pulse; leaves FAULT to IDLE
por_in  input  2  asynchronous POR-good per domain, bit0 = domain 1, 1 = supply good
en_out  output  2  domain enables, bit0 = domain 1
status  output  2  00 idle/in progress, 01 domain 1 good, 11 both good, 10 fault
checkbits  output  4  readback code (see Behaviour)
fault  output  1  high while in FAULT
done  output  1  high while in READY

Behaviour:
- Reset: resetb low at a clock edge sets the following:
  - state=IDLE;
  - en_out, status, checkbits, fault, done all 0;
  - synchronizer flops, debounce counter, timeout counter and settle counter all 0.
  Reset mid-sequence drops en_out on the same edge.
- Sync: each por_in bit passes through 2 flops (por_s).
- Debounce counter:
  - counts consecutive cycles in which por_s of the watched domain equals the awaited level;
  - any mismatch zeroes it;
  - it zeroes on every state change.
- Timeout counter:
  - zeroed on WAIT entry;
  - increments every cycle in WAIT1/WAIT2.
- States and transitions:
  - IDLE: en_out=00. start=1 -> WAIT1.
  - WAIT1: en_out=01. Debounce reaches DEBOUNCE_CYCLES with por_s[0]=1 -> SETTLE. Timeout reaches TIMEOUT_CYCLES -> FAULT, fcode=0.
  - SETTLE: en_out=01, status=01. After SETTLE_CYCLES cycles -> WAIT2. A debounced drop of por_s[0] (DEBOUNCE_CYCLES consecutive lows) -> FAULT, fcode=0.
  - WAIT2: en_out=11, status=01. Debounced por_s[1]=1 -> READY. Timeout -> FAULT, fcode=1. A debounced drop of por_s[0] -> FAULT, fcode=0.
  - READY: en_out=11, status=11, done=1. A debounced drop of either domain -> FAULT, fcode=index of the dropped domain; domain 0 wins if both drop together.
  - FAULT: en_out=00, status=10, fault=1. clear=1 -> IDLE. start is ignored.
- status encoding by state: IDLE and WAIT1 give 00; SETTLE and WAIT2 give 01; READY gives 11; FAULT gives 10.
- checkbits: IDLE and WAIT1 = 4'h0; SETTLE and WAIT2 = 4'h9; READY = 4'h5; FAULT = {3'b110, fcode}, i.e. 4'hC or 4'hD.
- All outputs are registered and change on the edge that enters the state.
- start in any non-IDLE state has no effect. start and clear in the same cycle in FAULT: clear wins, and start is not re-honoured on the IDLE entry cycle.
- Latency: with por_in[0] high before start, the sequence runs as follows:
  - WAIT1 entered at edge S+1;
  - SETTLE entered at edge S+1+DEBOUNCE_CYCLES (the synchronizer is already primed);
  - WAIT2 entered SETTLE_CYCLES edges later.
- Counters saturate and never wrap.
- Timeout takes priority over debounce completion on the same edge.

Test Plan:
1. Nominal: reset 4 cycles, por_in=11 held, start pulse -> en_out 01 then 11. At defaults, status=01 and checkbits=9 at edge 17 after start, and status=11, checkbits=5, done=1 at edge 41.
2. Late supply: por_in[1] rises 500 cycles after WAIT2 entry -> READY exactly 2+16 cycles after the rise; no fault.
3. Timeout: por_in[0] stuck 0 -> FAULT at 4096 cycles after WAIT1 entry, en_out=00, status=10, checkbits=C. clear -> IDLE with all outputs 0.
4. Glitch rejection: in READY, pulse por_in[1] low for 10 cycles -> stays READY. Hold it low for 20 cycles -> FAULT with checkbits=D.
5. Reset mid-WAIT2: resetb low for 1 cycle -> en_out=00 and status=00 the next edge. A new start replays the full sequence.
6. Start/clear collisions: start while READY -> no change. start+clear together in FAULT -> IDLE, no WAIT1 entry.
